// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Purpose:
//   Central stall/flush arbiter for a five-stage in-order pipeline. Each
//   cycle it picks one action (MEM_WAIT > FLUSH > HAZ > RUN) from the
//   hazard, branch and memory-handshake inputs. It drives the pipeline
//   freeze/bubble/flush controls combinationally from that action. It also
//   keeps saturating statistics counters and a sticky deadlock flag for
//   hazard stalls that persist too long.
//
// Parameters:
//   CNT_W          width of each statistics counter
//   MAX_HAZ_STALL  consecutive hazard-stall cycles that trip deadlock_err
//
// Ports:
//   clk              single clock, all state updates on rising edge
//   rst              synchronous, active-low reset
//   hazard_detected  data hazard flag from the hazard detection unit
//   branch_taken     taken branch resolved in EXE (may be a 1-cycle pulse)
//   mem_req          MEM stage has an access in progress
//   mem_ready        memory completes the access this cycle
//   clear_stats      synchronous clear of counters and deadlock_err
//   freeze_if/id/exe/mem  hold PC / IF-ID / ID-EXE / EXE-MEM registers
//   bubble_id_exe    load a NOP into the ID-EXE register
//   flush_if_id/flush_id_exe  clear the named pipeline register
//   state            action taken in the previous cycle (0 RUN, 1 HAZ,
//                    2 MEM_WAIT, 3 FLUSH)
//   haz_cnt/mem_cnt/flush_cnt  saturating per-action cycle counters
//   deadlock_err     sticky flag for an excessive consecutive hazard stall
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
    parameter int CNT_W         = 16,
    parameter int MAX_HAZ_STALL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clear_stats,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] haz_cnt,
    output logic [CNT_W-1:0] mem_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             deadlock_err
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZ      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } action_t;

    // The consecutive-hazard counter only has to count up to MAX_HAZ_STALL,
    // where it saturates.
    localparam int CONSEC_W_RAW = $clog2(MAX_HAZ_STALL + 1);
    localparam int CONSEC_W     = (CONSEC_W_RAW < 1) ? 1 : CONSEC_W_RAW;
    localparam logic [CONSEC_W-1:0] CONSEC_MAX  = CONSEC_W'(MAX_HAZ_STALL);
    localparam logic [CONSEC_W-1:0] CONSEC_TRIP = CONSEC_W'(MAX_HAZ_STALL - 1);
    localparam logic [CNT_W-1:0]    CNT_SAT     = '1;

    action_t             cur_action;
    action_t             state_q;
    logic                mem_stall;
    logic                pending_branch;
    logic [CONSEC_W-1:0] consec_cnt;
    logic [CNT_W-1:0]    haz_cnt_q;
    logic [CNT_W-1:0]    mem_cnt_q;
    logic [CNT_W-1:0]    flush_cnt_q;
    logic                deadlock_q;
    logic                trip_now;

    assign mem_stall = mem_req & ~mem_ready;

    // Action select and control decode. A branch seen during a memory wait
    // is remembered in pending_branch, so FLUSH still fires once the wait
    // ends even if branch_taken was only a pulse.
    always_comb begin
        cur_action    = ST_RUN;
        freeze_if     = 1'b0;
        freeze_id     = 1'b0;
        freeze_exe    = 1'b0;
        freeze_mem    = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_exe  = 1'b0;
        if (mem_stall) begin
            cur_action = ST_MEM_WAIT;
            freeze_if  = 1'b1;
            freeze_id  = 1'b1;
            freeze_exe = 1'b1;
            freeze_mem = 1'b1;
        end else if (branch_taken || pending_branch) begin
            cur_action   = ST_FLUSH;
            flush_if_id  = 1'b1;
            flush_id_exe = 1'b1;
        end else if (hazard_detected) begin
            cur_action    = ST_HAZ;
            freeze_if     = 1'b1;
            freeze_id     = 1'b1;
            bubble_id_exe = 1'b1;
        end
    end

    // The deadlock flag is raised on the edge where the consecutive counter
    // steps up to MAX_HAZ_STALL.
    assign trip_now = (cur_action == ST_HAZ) && (consec_cnt == CONSEC_TRIP);

    // Action history, pending branch and consecutive-hazard tracking. These
    // are not touched by clear_stats; only reset abandons them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            pending_branch <= 1'b0;
            consec_cnt     <= '0;
        end else begin
            state_q <= cur_action;
            if (cur_action == ST_FLUSH) begin
                pending_branch <= 1'b0;
            end else if (branch_taken && mem_stall) begin
                pending_branch <= 1'b1;
            end
            case (cur_action)
                ST_HAZ: begin
                    if (consec_cnt != CONSEC_MAX) begin
                        consec_cnt <= consec_cnt + CONSEC_W'(1);
                    end
                end
                ST_MEM_WAIT: consec_cnt <= consec_cnt;
                default:     consec_cnt <= '0;
            endcase
        end
    end

    // Statistics counters and the sticky deadlock flag. clear_stats wins over
    // any increment or trip in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst || clear_stats) begin
            haz_cnt_q   <= '0;
            mem_cnt_q   <= '0;
            flush_cnt_q <= '0;
            deadlock_q  <= 1'b0;
        end else begin
            if (cur_action == ST_HAZ && haz_cnt_q != CNT_SAT) begin
                haz_cnt_q <= haz_cnt_q + CNT_W'(1);
            end
            if (cur_action == ST_MEM_WAIT && mem_cnt_q != CNT_SAT) begin
                mem_cnt_q <= mem_cnt_q + CNT_W'(1);
            end
            if (cur_action == ST_FLUSH && flush_cnt_q != CNT_SAT) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (trip_now) begin
                deadlock_q <= 1'b1;
            end
        end
    end

    assign state        = state_q;
    assign haz_cnt      = haz_cnt_q;
    assign mem_cnt      = mem_cnt_q;
    assign flush_cnt    = flush_cnt_q;
    assign deadlock_err = deadlock_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Purpose:
//   Self-checking bench for pipeline_stall_controller. A reference model
//   predicts the control outputs and post-edge registered values for every
//   driven cycle. It pushes those predictions to a queue, and the per-scenario
//   tasks pop and compare them against what the DUT produced.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

    localparam int CNT_W = 16;
    localparam int MAX_H = 4;

    logic             clk;
    logic             rst;
    logic             hazard_detected;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             clear_stats;
    logic             freeze_if;
    logic             freeze_id;
    logic             freeze_exe;
    logic             freeze_mem;
    logic             bubble_id_exe;
    logic             flush_if_id;
    logic             flush_id_exe;
    logic [1:0]       state;
    logic [CNT_W-1:0] haz_cnt;
    logic [CNT_W-1:0] mem_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             deadlock_err;

    pipeline_stall_controller #(
        .CNT_W         (CNT_W),
        .MAX_HAZ_STALL (MAX_H)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .clear_stats     (clear_stats),
        .freeze_if       (freeze_if),
        .freeze_id       (freeze_id),
        .freeze_exe      (freeze_exe),
        .freeze_mem      (freeze_mem),
        .bubble_id_exe   (bubble_id_exe),
        .flush_if_id     (flush_if_id),
        .flush_id_exe    (flush_id_exe),
        .state           (state),
        .haz_cnt         (haz_cnt),
        .mem_cnt         (mem_cnt),
        .flush_cnt       (flush_cnt),
        .deadlock_err    (deadlock_err)
    );

    // ctrl = {freeze_if, freeze_id, freeze_exe, freeze_mem, bubble, flush_if_id, flush_id_exe}
    // regs = {state, haz_cnt, mem_cnt, flush_cnt, deadlock_err}
    typedef struct packed {
        logic [6:0]  ctrl;
        logic [50:0] regs;
    } obs_t;

    obs_t exp_q[$];
    obs_t act_q[$];

    int cnt_compared   = 0;
    int cnt_mismatched = 0;

    // Reference model state
    logic             m_pend;
    logic [1:0]       m_state;
    logic [CNT_W-1:0] m_haz;
    logic [CNT_W-1:0] m_mem;
    logic [CNT_W-1:0] m_fl;
    int               m_consec;
    logic             m_derr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one cycle (entered 1 time unit after a rising edge), records the
    // DUT's control outputs mid-cycle and its registered outputs after the
    // edge, and queues the model's prediction for both.
    task automatic drive_cycle(input logic r, input logic hz, input logic br,
                               input logic mr, input logic mrdy, input logic clr);
        obs_t       e;
        obs_t       a;
        logic       ms;
        logic [1:0] c;
        logic       trip;
        rst             = r;
        hazard_detected = hz;
        branch_taken    = br;
        mem_req         = mr;
        mem_ready       = mrdy;
        clear_stats     = clr;
        #3;
        a.ctrl = {freeze_if, freeze_id, freeze_exe, freeze_mem,
                  bubble_id_exe, flush_if_id, flush_id_exe};
        ms = mr & ~mrdy;
        if (ms)              c = 2'd2;
        else if (br || m_pend) c = 2'd3;
        else if (hz)         c = 2'd1;
        else                 c = 2'd0;
        case (c)
            2'd2:    e.ctrl = 7'b1111000;
            2'd3:    e.ctrl = 7'b0000011;
            2'd1:    e.ctrl = 7'b1100100;
            default: e.ctrl = 7'b0000000;
        endcase
        if (!r) begin
            m_pend = 1'b0; m_state = 2'd0; m_consec = 0;
            m_haz = '0; m_mem = '0; m_fl = '0; m_derr = 1'b0;
        end else begin
            m_state = c;
            if (c == 2'd3)      m_pend = 1'b0;
            else if (br && ms)  m_pend = 1'b1;
            trip = (c == 2'd1) && (m_consec == MAX_H - 1);
            if (c == 2'd1)      m_consec = (m_consec < MAX_H) ? m_consec + 1 : MAX_H;
            else if (c != 2'd2) m_consec = 0;
            if (clr) begin
                m_haz = '0; m_mem = '0; m_fl = '0; m_derr = 1'b0;
            end else begin
                if (c == 2'd1 && m_haz != 16'hFFFF) m_haz = m_haz + 16'd1;
                if (c == 2'd2 && m_mem != 16'hFFFF) m_mem = m_mem + 16'd1;
                if (c == 2'd3 && m_fl  != 16'hFFFF) m_fl  = m_fl  + 16'd1;
                if (trip) m_derr = 1'b1;
            end
        end
        e.regs = {m_state, m_haz, m_mem, m_fl, m_derr};
        @(posedge clk);
        #1;
        a.regs = {state, haz_cnt, mem_cnt, flush_cnt, deadlock_err};
        exp_q.push_back(e);
        act_q.push_back(a);
    endtask

    task automatic test_reset();
        obs_t e;
        obs_t a;
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_compared++;
        if ({state, haz_cnt, mem_cnt, flush_cnt, deadlock_err} !== 51'd0) begin
            cnt_mismatched++;
            $display("[TB] FAIL reset_regs: got %h expected 0",
                     {state, haz_cnt, mem_cnt, flush_cnt, deadlock_err});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            cnt_compared++;
            if (a.ctrl !== e.ctrl) begin
                cnt_mismatched++;
                $display("[TB] FAIL reset_ctrl: got %b expected %b", a.ctrl, e.ctrl);
            end
            cnt_compared++;
            if (a.regs !== e.regs) begin
                cnt_mismatched++;
                $display("[TB] FAIL reset_model: got %h expected %h", a.regs, e.regs);
            end
        end
    endtask

    task automatic test_hazard();
        obs_t e;
        obs_t a;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_compared++;
        if (state !== 2'd1 || haz_cnt !== 16'd1) begin
            cnt_mismatched++;
            $display("[TB] FAIL hazard_one: got state=%0d haz_cnt=%0d expected state=1 haz_cnt=1",
                     state, haz_cnt);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            cnt_compared++;
            if (a.ctrl !== e.ctrl) begin
                cnt_mismatched++;
                $display("[TB] FAIL hazard_ctrl: got %b expected %b", a.ctrl, e.ctrl);
            end
            cnt_compared++;
            if (a.regs !== e.regs) begin
                cnt_mismatched++;
                $display("[TB] FAIL hazard_model: got %h expected %h", a.regs, e.regs);
            end
        end
    endtask

    task automatic test_mem_branch();
        obs_t e;
        obs_t a;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        cnt_compared++;
        if (mem_cnt !== 16'd3 || flush_cnt !== 16'd1 || state !== 2'd3) begin
            cnt_mismatched++;
            $display("[TB] FAIL mem_branch_counts: got mem=%0d flush=%0d state=%0d expected 3 1 3",
                     mem_cnt, flush_cnt, state);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            cnt_compared++;
            if (a.ctrl !== e.ctrl) begin
                cnt_mismatched++;
                $display("[TB] FAIL mem_branch_ctrl: got %b expected %b", a.ctrl, e.ctrl);
            end
            cnt_compared++;
            if (a.regs !== e.regs) begin
                cnt_mismatched++;
                $display("[TB] FAIL mem_branch_model: got %h expected %h", a.regs, e.regs);
            end
        end
    endtask

    task automatic test_haz_and_branch();
        obs_t e;
        obs_t a;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cnt_compared++;
        if (haz_cnt !== 16'd0 || flush_cnt !== 16'd1) begin
            cnt_mismatched++;
            $display("[TB] FAIL haz_branch_counts: got haz=%0d flush=%0d expected 0 1",
                     haz_cnt, flush_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            cnt_compared++;
            if (a.ctrl !== e.ctrl) begin
                cnt_mismatched++;
                $display("[TB] FAIL haz_branch_ctrl: got %b expected %b", a.ctrl, e.ctrl);
            end
            cnt_compared++;
            if (a.regs !== e.regs) begin
                cnt_mismatched++;
                $display("[TB] FAIL haz_branch_model: got %h expected %h", a.regs, e.regs);
            end
        end
    endtask

    task automatic test_deadlock();
        obs_t e;
        obs_t a;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_compared++;
        if (deadlock_err !== 1'b0) begin
            cnt_mismatched++;
            $display("[TB] FAIL deadlock_early: got %b expected 0", deadlock_err);
        end
        drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_compared++;
        if (deadlock_err !== 1'b1) begin
            cnt_mismatched++;
            $display("[TB] FAIL deadlock_sticky: got %b expected 1", deadlock_err);
        end
        drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cnt_compared++;
        if (deadlock_err !== 1'b0 || haz_cnt !== 16'd0) begin
            cnt_mismatched++;
            $display("[TB] FAIL deadlock_clear: got derr=%b haz=%0d expected 0 0",
                     deadlock_err, haz_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            cnt_compared++;
            if (a.ctrl !== e.ctrl) begin
                cnt_mismatched++;
                $display("[TB] FAIL deadlock_ctrl: got %b expected %b", a.ctrl, e.ctrl);
            end
            cnt_compared++;
            if (a.regs !== e.regs) begin
                cnt_mismatched++;
                $display("[TB] FAIL deadlock_model: got %h expected %h", a.regs, e.regs);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        obs_t a;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(0, 29) != 0), $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            cnt_compared++;
            if (a.ctrl !== e.ctrl) begin
                cnt_mismatched++;
                $display("[TB] FAIL random_ctrl: got %b expected %b", a.ctrl, e.ctrl);
            end
            cnt_compared++;
            if (a.regs !== e.regs) begin
                cnt_mismatched++;
                $display("[TB] FAIL random_model: got %h expected %h", a.regs, e.regs);
            end
        end
    endtask

    task automatic test_saturation();
        obs_t e;
        obs_t a;
        drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Walk haz_cnt up to 0xFFFE with real HAZ cycles.
        for (int i = 0; i < 65534; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_compared++;
        if (haz_cnt !== 16'hFFFE) begin
            cnt_mismatched++;
            $display("[TB] FAIL sat_preload: got %h expected fffe", haz_cnt);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_compared++;
        if (haz_cnt !== 16'hFFFF) begin
            cnt_mismatched++;
            $display("[TB] FAIL sat_nowrap: got %h expected ffff", haz_cnt);
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cnt_compared++;
        if ({state, haz_cnt, mem_cnt, flush_cnt, deadlock_err} !== 51'd0) begin
            cnt_mismatched++;
            $display("[TB] FAIL sat_reset: got %h expected 0",
                     {state, haz_cnt, mem_cnt, flush_cnt, deadlock_err});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = act_q.pop_front();
            cnt_compared++;
            if (a.ctrl !== e.ctrl) begin
                cnt_mismatched++;
                $display("[TB] FAIL sat_ctrl: got %b expected %b", a.ctrl, e.ctrl);
            end
            cnt_compared++;
            if (a.regs !== e.regs) begin
                cnt_mismatched++;
                $display("[TB] FAIL sat_model: got %h expected %h", a.regs, e.regs);
            end
        end
    endtask

    initial begin
        rst             = 1'b0;
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        clear_stats     = 1'b0;
        m_pend = 1'b0; m_state = 2'd0; m_consec = 0;
        m_haz = '0; m_mem = '0; m_fl = '0; m_derr = 1'b0;
        // Bring the DUT to a known state before any prediction is checked.
        @(posedge clk);
        @(posedge clk);
        #1;
        $display("[TB] starting pipeline_stall_controller bench");
        test_reset();
        test_hazard();
        test_mem_branch();
        test_haz_and_branch();
        test_deadlock();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_compared, cnt_mismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
PIPELINE_STALL_CONTROLLER -- requirements
Module: pipeline_stall_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-002 SHALL have parameter MAX_HAZ_STALL, default 4, giving the consecutive hazard-stall cycles that trip deadlock_err.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port hazard_detected, input, 1, data hazard flag from the hazard detection unit.
REQ-006 SHALL have port branch_taken, input, 1, taken branch resolved in EXE; may be a one-cycle pulse.
REQ-007 SHALL have port mem_req, input, 1, MEM stage has a memory access in progress.
REQ-008 SHALL have port mem_ready, input, 1, memory completes the access this cycle.
REQ-009 SHALL have port clear_stats, input, 1, synchronous clear of counters and deadlock_err.
REQ-010 SHALL have ports freeze_if, freeze_id, freeze_exe, freeze_mem, output, 1 each, hold the PC / IF-ID / ID-EXE / EXE-MEM registers.
REQ-011 SHALL have port bubble_id_exe, output, 1, load NOP into the ID-EXE register.
REQ-012 SHALL have ports flush_if_id, flush_id_exe, output, 1 each, clear the named pipeline register.
REQ-013 SHALL have port state, output, 2, action taken in the previous cycle: 0 RUN, 1 HAZ, 2 MEM_WAIT, 3 FLUSH.
REQ-014 SHALL have ports haz_cnt, mem_cnt, flush_cnt, output, CNT_W each, statistics counters.
REQ-015 SHALL have port deadlock_err, output, 1, sticky flag for an excessive consecutive hazard stall.

Function
REQ-016 SHALL define mem_stall = mem_req AND NOT mem_ready.
REQ-017 SHALL drive control outputs combinationally each cycle by fixed priority: MEM_WAIT > FLUSH > HAZ > RUN.
REQ-018 SHALL, in the MEM_WAIT case (mem_stall=1), drive all four freeze outputs 1 and bubble and both flushes 0.
REQ-019 SHALL, in the FLUSH case (no mem_stall, branch_taken OR pending_branch), drive flush_if_id and flush_id_exe 1 and freezes and bubble 0.
REQ-020 SHALL, in the HAZ case (no mem_stall, no branch, hazard_detected), drive freeze_if, freeze_id and bubble_id_exe 1; freeze_exe, freeze_mem and flushes 0.
REQ-021 SHALL, in the RUN case, drive all control outputs 0.
REQ-022 SHALL set internal pending_branch when branch_taken=1 and mem_stall=1, and clear it on the first FLUSH-case cycle; a branch SHALL never be lost across a memory wait.
REQ-023 SHALL register the chosen case into state at each clock edge, so state lags the outputs by one cycle.
REQ-024 SHALL increment haz_cnt, mem_cnt or flush_cnt by 1 on each HAZ, MEM_WAIT or FLUSH cycle respectively, saturating at all-ones without wrapping.
REQ-025 SHALL keep an internal consecutive-hazard counter: +1 per HAZ cycle, held on MEM_WAIT cycles, cleared on RUN or FLUSH cycles.
REQ-026 SHALL set deadlock_err on the edge where the consecutive-hazard counter reaches MAX_HAZ_STALL; it remains 1 until clear_stats or reset.
REQ-027 SHALL give clear_stats priority over same-cycle increments: counters and deadlock_err become 0; state, pending_branch and the consecutive counter are unaffected.

Reset
REQ-028 SHALL, on a rising edge with rst=0, set state=RUN, pending_branch=0, all counters 0, consecutive counter 0, and deadlock_err=0, regardless of other inputs.
REQ-029 SHALL leave combinational control outputs driven by current inputs during reset; the pipeline owner gates them with rst.
REQ-030 SHALL treat reset mid-stall or mid-flush as full abandonment: no pending branch survives reset.

Verification
REQ-031 SHALL cover: hazard_detected=1 for 1 cycle -> freeze_if=freeze_id=bubble_id_exe=1 that cycle, state=1 next cycle, haz_cnt=1.
REQ-032 SHALL cover: mem_req=1, mem_ready=0 for 3 cycles with a branch_taken pulse in cycle 1 -> 3 cycles of all freezes, then mem_ready=1 -> flush_if_id=flush_id_exe=1 the next cycle, mem_cnt=3, flush_cnt=1.
REQ-033 SHALL cover: hazard_detected and branch_taken together -> flush only, bubble_id_exe=0, haz_cnt unchanged.
REQ-034 SHALL cover: hazard_detected held 4 cycles with MAX_HAZ_STALL=4 -> deadlock_err=1 after the 4th edge and still 1 after hazard drops; clear_stats -> 0.
REQ-035 SHALL cover: haz_cnt preloaded to 0xFFFE, then 3 HAZ cycles -> 0xFFFF with no wrap; rst=0 mid-sequence -> all counters 0 and state=RUN on the next edge.
